// File: rtl/swu_ram_read_ctrl.sv
// Read-side sequencer for the sliding-window buffer RAM: issues narrow reads, streams them out on AXI-Stream, returns wide-slot credits.
// Latency: wr_commit in cycle N gives enaB in N+1, enaB_q in N+2, m_axis_tvalid in N+3; 1 beat/cycle sustained.
// Backpressure: m_axis_tready low freezes stage 2, then stage 1; issue stops with at most 2 beats in flight.
module swu_ram_read_ctrl #(
  parameter int WIDTHB     = 4,
  parameter int SIZEB      = 1024,
  parameter int ADDRWIDTHB = 10,
  parameter int WIDTHA     = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_commit,
  output logic                  rd_credit,
  output logic [ADDRWIDTHB-1:0] addrB,
  output logic                  enaB,
  output logic                  enaB_q,
  input  logic [WIDTHB-1:0]     doB,
  output logic [WIDTHB-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ADDRWIDTHB:0]   occupancy,
  output logic                  overflow
);

  localparam int RATIO = WIDTHA / WIDTHB;
  localparam int BCW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  // Low pointer bits that select the narrow word within a wide slot.
  localparam logic [ADDRWIDTHB-1:0] SLOT_MASK = ADDRWIDTHB'(RATIO - 1);
  // Highest occupancy at which a further wide word still fits.
  localparam logic [ADDRWIDTHB:0]   OCC_LIMIT = (ADDRWIDTHB + 1)'(SIZEB - RATIO);
  localparam logic [ADDRWIDTHB:0]   OCC_STEP  = (ADDRWIDTHB + 1)'(RATIO);
  localparam logic [BCW-1:0]        LAST_BEAT = BCW'(FRAME_LEN - 1);

  logic [ADDRWIDTHB-1:0] rdPtr;
  logic [ADDRWIDTHB:0]   occCnt;
  logic                  v1;
  logic                  v2;
  logic [BCW-1:0]        beatCnt;
  logic                  creditQ;
  logic                  overflowQ;

  logic adv2;
  logic issue;
  logic commitOk;
  logic slotEnd;
  logic handshake;

  // Pipeline advance / issue decisions; stage 2 may move when it is empty or being drained.
  always_comb begin
    adv2      = v1 & (~v2 | m_axis_tready);
    issue     = (occCnt != '0) & (~v1 | adv2);
    commitOk  = wr_commit & (occCnt <= OCC_LIMIT);
    slotEnd   = (rdPtr & SLOT_MASK) == SLOT_MASK;
    handshake = v2 & m_axis_tready;
  end

  // Read pointer walks the ring sequentially; occupancy nets commits against issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr  <= '0;
      occCnt <= '0;
    end else begin
      if (issue) rdPtr <= rdPtr + 1'b1;
      occCnt <= occCnt + (commitOk ? OCC_STEP : '0) - {{ADDRWIDTHB{1'b0}}, issue};
    end
  end

  // Two-stage valid tracking mirroring the RAM's readB and doB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= issue | (v1 & ~adv2);
      v2 <= adv2 | (v2 & ~m_axis_tready);
    end
  end

  // Credit pulse after the last narrow word of a wide slot is issued; sticky overflow on a commit that cannot fit.
  always_ff @(posedge clk) begin
    if (rst) begin
      creditQ   <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      creditQ <= issue & slotEnd;
      if (wr_commit & ~commitOk) overflowQ <= 1'b1;
    end
  end

  // Beat position within the current output frame, advanced on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      beatCnt <= '0;
    end else if (handshake) begin
      beatCnt <= (beatCnt == LAST_BEAT) ? '0 : beatCnt + 1'b1;
    end
  end

  assign addrB         = rdPtr;
  assign enaB          = issue;
  assign enaB_q        = adv2;
  assign m_axis_tdata  = doB;
  assign m_axis_tvalid = v2;
  assign m_axis_tlast  = v2 & (beatCnt == LAST_BEAT);
  assign occupancy     = occCnt;
  assign overflow      = overflowQ;
  assign rd_credit     = creditQ;

endmodule

// File: tb/tb_swu_ram_read_ctrl.sv
// Bench for swu_ram_read_ctrl with a small asymmetric RAM model and a queue-based stream reference.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled just after the falling edge.
// Backpressure: tready driven directed or randomly per cycle.
module tb_swu_ram_read_ctrl;
  localparam int WA = 16;
  localparam int WB = 4;
  localparam int SZ = 16;
  localparam int AW = 4;
  localparam int FL = 6;
  localparam int R  = WA / WB;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_commit;
  logic          rd_credit;
  logic [AW-1:0] addrB;
  logic          enaB;
  logic          enaB_q;
  logic [WB-1:0] doB;
  logic [WB-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [AW:0]   occupancy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  swu_ram_read_ctrl #(
    .WIDTHB(WB), .SIZEB(SZ), .ADDRWIDTHB(AW), .WIDTHA(WA), .FRAME_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .wr_commit(wr_commit), .rd_credit(rd_credit),
    .addrB(addrB), .enaB(enaB), .enaB_q(enaB_q), .doB(doB),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .occupancy(occupancy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural buffer RAM: narrow words, two registered read stages.
  logic [WB-1:0] mem [SZ];
  logic [WB-1:0] readB;
  always @(posedge clk) begin
    if (enaB)   readB <= mem[addrB];
    if (enaB_q) doB   <= readB;
  end

  // Reference: every accepted narrow word in write order.
  logic [WB-1:0] expQ [$];
  int            wptr;

  // Observed stream and event counts since the last reset.
  logic [WB-1:0] gotData [$];
  logic          gotLast [$];
  int            gotCyc  [$];
  int            creditCnt;
  int            issueCnt;
  int            cyc = 0;

  // Record handshakes, credits and issues once per cycle.
  always @(negedge clk) begin
    if (rst) begin
      gotData.delete();
      gotLast.delete();
      gotCyc.delete();
      creditCnt = 0;
      issueCnt  = 0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        gotData.push_back(m_axis_tdata);
        gotLast.push_back(m_axis_tlast);
        gotCyc.push_back(cyc);
      end
      if (rd_credit) creditCnt++;
      if (enaB) issueCnt++;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Assert wr_commit for the current cycle; accepted words land in the RAM and the reference queue.
  task automatic commit_word(input logic [WA-1:0] w, input bit accepted);
    wr_commit = 1'b1;
    if (accepted) begin
      for (int i = 0; i < R; i++) begin
        mem[(wptr + i) % SZ] = w[i*WB +: WB];
        expQ.push_back(w[i*WB +: WB]);
      end
      wptr = (wptr + R) % SZ;
    end
  endtask

  task automatic apply_reset(input logic tr);
    rst = 1'b1;
    wr_commit = 1'b0;
    m_axis_tready = tr;
    step();
    step();
    rst = 1'b0;
    expQ.delete();
    wptr = 0;
  endtask

  task automatic wait_beats(input int n, input int maxCyc, output bit timedOut);
    int k;
    k = 0;
    timedOut = 1'b0;
    while (gotData.size() < n) begin
      sample();
      k++;
      if (k > maxCyc) begin
        timedOut = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    sample();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", m_axis_tvalid); end
    checks++; if (enaB !== 1'b0) begin errors++; $display("FAIL reset_enaB got %b exp 0", enaB); end
    checks++; if (enaB_q !== 1'b0) begin errors++; $display("FAIL reset_enaB_q got %b exp 0", enaB_q); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", m_axis_tlast); end
    checks++; if (addrB !== '0) begin errors++; $display("FAIL reset_addrB got %0d exp 0", addrB); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (rd_credit !== 1'b0) begin errors++; $display("FAIL reset_credit got %b exp 0", rd_credit); end
  endtask

  // One wide word with free-flowing output: cycle-exact address, data and credit timing.
  task automatic test_single_commit();
    logic [WB-1:0] expD;
    apply_reset(1'b1);
    step();
    commit_word(16'hDCBA, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      step();
      wr_commit = 1'b0;
      sample();
      checks++; if (enaB !== (k >= 1 && k <= 4)) begin errors++; $display("FAIL single_enaB N+%0d got %b exp %b", k, enaB, (k >= 1 && k <= 4)); end
      if (k <= 4) begin
        checks++; if (addrB !== AW'(k - 1)) begin errors++; $display("FAIL single_addrB N+%0d got %0d exp %0d", k, addrB, k - 1); end
      end
      checks++; if (m_axis_tvalid !== (k >= 3 && k <= 6)) begin errors++; $display("FAIL single_tvalid N+%0d got %b exp %b", k, m_axis_tvalid, (k >= 3 && k <= 6)); end
      if (k >= 3 && k <= 6) begin
        expD = WB'(4'hA + k - 3);
        checks++; if (m_axis_tdata !== expD) begin errors++; $display("FAIL single_tdata N+%0d got %h exp %h", k, m_axis_tdata, expD); end
      end
      checks++; if (rd_credit !== (k == 5)) begin errors++; $display("FAIL single_credit N+%0d got %b exp %b", k, rd_credit, (k == 5)); end
    end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL single_occupancy got %0d exp 0", occupancy); end
  endtask

  // Four back-to-back commits fill the whole ring and stream contiguously across the pointer wrap.
  task automatic test_back_to_back();
    bit to;
    int lasts;
    apply_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      commit_word(WA'($urandom), 1'b1);
    end
    step();
    wr_commit = 1'b0;
    wait_beats(16, 60, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout got %0d beats exp 16", gotData.size()); end
    if (!to) begin
      lasts = 0;
      for (int i = 0; i < 16; i++) begin
        lasts += int'(gotLast[i]);
        checks++; if (gotData[i] !== expQ[i] || gotLast[i] !== (i % FL == FL - 1)) begin errors++; $display("FAIL b2b_beat%0d got %h/%b exp %h/%b", i, gotData[i], gotLast[i], expQ[i], (i % FL == FL - 1)); end
      end
      checks++; if (gotCyc[15] - gotCyc[0] !== 15) begin errors++; $display("FAIL b2b_contiguous got span %0d exp 15", gotCyc[15] - gotCyc[0]); end
      checks++; if (lasts !== 2) begin errors++; $display("FAIL b2b_tlast_count got %0d exp 2", lasts); end
    end
    repeat (3) sample();
    checks++; if (creditCnt !== 4) begin errors++; $display("FAIL b2b_credits got %0d exp 4", creditCnt); end
    checks++; if (addrB !== '0) begin errors++; $display("FAIL b2b_wrap_addrB got %0d exp 0", addrB); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL b2b_occupancy got %0d exp 0", occupancy); end
  endtask

  // Output blocked from the start: two reads fill the pipe, data holds, then eight beats drain in order.
  task automatic test_stall();
    bit to;
    apply_reset(1'b0);
    step();
    commit_word(16'hDCBA, 1'b1);
    step();
    commit_word(WA'($urandom), 1'b1);
    step();
    wr_commit = 1'b0;
    repeat (8) step();
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== expQ[0]) begin errors++; $display("FAIL stall_hold%0d got %b/%h exp 1/%h", k, m_axis_tvalid, m_axis_tdata, expQ[0]); end
    end
    checks++; if (issueCnt !== 2) begin errors++; $display("FAIL stall_issues got %0d exp 2", issueCnt); end
    checks++; if (occupancy !== 6) begin errors++; $display("FAIL stall_occupancy got %0d exp 6", occupancy); end
    checks++; if (gotData.size() !== 0) begin errors++; $display("FAIL stall_no_beats got %0d exp 0", gotData.size()); end
    step();
    m_axis_tready = 1'b1;
    wait_beats(8, 40, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout got %0d beats exp 8", gotData.size()); end
    repeat (2) sample();
    checks++; if (gotData.size() !== 8) begin errors++; $display("FAIL stall_beat_count got %0d exp 8", gotData.size()); end
    for (int i = 0; i < gotData.size() && i < 8; i++) begin
      checks++; if (gotData[i] !== expQ[i]) begin errors++; $display("FAIL stall_beat%0d got %h exp %h", i, gotData[i], expQ[i]); end
    end
    checks++; if (issueCnt !== 8) begin errors++; $display("FAIL stall_total_issues got %0d exp 8", issueCnt); end
    checks++; if (creditCnt !== 2) begin errors++; $display("FAIL stall_credits got %0d exp 2", creditCnt); end
  endtask

  // Random commits against random backpressure; the stream must equal the written narrow sequence.
  task automatic test_random();
    int nCommit;
    int k;
    bit done;
    apply_reset(1'b0);
    nCommit = 0;
    k = 0;
    done = 1'b0;
    while (!done && k < 5000) begin
      step();
      m_axis_tready = 1'($urandom_range(0, 1));
      wr_commit = 1'b0;
      if (nCommit < 100 && (expQ.size() - gotData.size()) <= SZ - R && $urandom_range(0, 1) == 1) begin
        commit_word(WA'($urandom), 1'b1);
        nCommit++;
      end
      sample();
      k++;
      done = (nCommit == 100) && (gotData.size() >= 100 * R);
    end
    step();
    wr_commit = 1'b0;
    m_axis_tready = 1'b1;
    checks++; if (!done) begin errors++; $display("FAIL rand_timeout got %0d beats exp %0d", gotData.size(), 100 * R); end
    for (int i = 0; i < gotData.size() && i < expQ.size(); i++) begin
      checks++; if (gotData[i] !== expQ[i] || gotLast[i] !== (i % FL == FL - 1)) begin errors++; $display("FAIL rand_beat%0d got %h/%b exp %h/%b", i, gotData[i], gotLast[i], expQ[i], (i % FL == FL - 1)); end
    end
    repeat (4) sample();
    checks++; if (gotData.size() !== 100 * R) begin errors++; $display("FAIL rand_beat_count got %0d exp %0d", gotData.size(), 100 * R); end
    checks++; if (creditCnt !== 100) begin errors++; $display("FAIL rand_credits got %0d exp 100", creditCnt); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL rand_occupancy got %0d exp 0", occupancy); end
  endtask

  // Commit at occupancy 13 is refused and flagged, while the concurrent issue still decrements.
  task automatic test_overflow();
    bit to;
    apply_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      commit_word(WA'($urandom), 1'b1);
    end
    step();
    wr_commit = 1'b0;
    repeat (8) step();
    sample();
    checks++; if (occupancy !== 14) begin errors++; $display("FAIL ovf_settle_occ got %0d exp 14", occupancy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
    step();
    m_axis_tready = 1'b1;
    step();
    commit_word(WA'($urandom), 1'b0);
    sample();
    checks++; if (occupancy !== 13) begin errors++; $display("FAIL ovf_pre_occ got %0d exp 13", occupancy); end
    step();
    wr_commit = 1'b0;
    sample();
    checks++; if (occupancy !== 12) begin errors++; $display("FAIL ovf_post_occ got %0d exp 12", occupancy); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    wait_beats(16, 60, to);
    repeat (3) sample();
    checks++; if (gotData.size() !== 16) begin errors++; $display("FAIL ovf_beat_count got %0d exp 16", gotData.size()); end
    for (int i = 0; i < gotData.size() && i < 16; i++) begin
      checks++; if (gotData[i] !== expQ[i]) begin errors++; $display("FAIL ovf_beat%0d got %h exp %h", i, gotData[i], expQ[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  // Reset with a full pipe, occupancy 5 and overflow set clears everything in one edge.
  task automatic test_reset_midop();
    m_axis_tready = 1'b0;
    step();
    commit_word(WA'($urandom), 1'b1);
    step();
    commit_word(WA'($urandom), 1'b1);
    step();
    wr_commit = 1'b0;
    repeat (5) step();
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    repeat (3) step();
    sample();
    checks++; if (occupancy !== 5 || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL midop_setup got occ %0d tvalid %b exp 5 1", occupancy, m_axis_tvalid); end
    step();
    rst = 1'b1;
    step();
    sample();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midop_tvalid got %b exp 0", m_axis_tvalid); end
    checks++; if (enaB !== 1'b0) begin errors++; $display("FAIL midop_enaB got %b exp 0", enaB); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL midop_occupancy got %0d exp 0", occupancy); end
    checks++; if (addrB !== '0) begin errors++; $display("FAIL midop_addrB got %0d exp 0", addrB); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midop_overflow got %b exp 0", overflow); end
    apply_reset(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    wr_commit = 1'b0;
    m_axis_tready = 1'b0;
    wptr = 0;
    doB = '0;
    readB = '0;
    for (int i = 0; i < SZ; i++) mem[i] = '0;
    test_reset();
    test_single_commit();
    test_back_to_back();
    test_stall();
    test_random();
    test_overflow();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swu_ram_read_ctrl.md
Name: swu_ram_read_ctrl

Overview:
- Read-side sequencer for the sliding-window unit's asymmetric buffer RAM. The RAM is written as wide words on port A and read as narrow words on port B.
- Tracks buffer occupancy in narrow words and drives the RAM's addrB/enaB/enaB_q two-stage read pipeline.
- Presents read data as an AXI-Stream master with full backpressure and per-frame tlast.
- Returns one wide-slot credit to the upstream write controller whenever a wide word has been fully read.

Parameters:
- WIDTHB, 4: narrow (read) word width.
- SIZEB, 1024: RAM depth in narrow words; power of two.
- ADDRWIDTHB, 10: log2(SIZEB).
- WIDTHA, 16: wide (write) word width; WIDTHA = RATIO*WIDTHB, RATIO a power of two ≥ 1.
- FRAME_LEN, 64: narrow beats per output frame; tlast on the last beat; ≥ 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_commit  in  1  one wide word (RATIO narrow words) has been written to the RAM this cycle.
- rd_credit  out  1  one-cycle pulse: one wide slot is free for reuse.
- addrB  out  ADDRWIDTHB  RAM read address.
- enaB  out  1  RAM stage-1 enable (readB <= RAM[addrB]).
- enaB_q  out  1  RAM stage-2 enable (doB <= readB).
- doB  in  WIDTHB  RAM read data.
- m_axis_tdata  out  WIDTHB  equals doB.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of frame.
- occupancy  out  ADDRWIDTHB+1  narrow words committed but not yet issued.
- overflow  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: rd_ptr=0, occupancy=0, v1=0, v2=0, beat_cnt=0, rd_credit=0, overflow=0. Consequently enaB=0, enaB_q=0, tvalid=0, tlast=0, addrB=0.
- Pipeline state: v1 marks RAM readB valid; v2 marks doB valid. m_axis_tvalid = v2.
- Stage-2 advance: adv2 = v1 & (~v2 | m_axis_tready). enaB_q = adv2.
- Issue: issue = (occupancy != 0) & (~v1 | adv2). enaB = issue. addrB = rd_ptr, combinational from the register.
- v1 next: issue | (v1 & ~adv2).
- v2 next: adv2 | (v2 & ~m_axis_tready).
- On issue: rd_ptr <= rd_ptr+1, wrapping SIZEB-1 → 0. The address sequence is strictly sequential.
- Occupancy: +RATIO on wr_commit, -1 on issue. Simultaneous events give a net change of RATIO-1 in one cycle.
- Overflow: wr_commit while occupancy > SIZEB-RATIO sets overflow (sticky until rst) and the increment is discarded.
- Credit: rd_credit is registered, high the cycle after an issue where rd_ptr[log2(RATIO)-1:0] is all ones. With RATIO=1 it follows every issue.
- Framing: m_axis_tlast = v2 & (beat_cnt == FRAME_LEN-1). On each tvalid&tready, beat_cnt increments and wraps FRAME_LEN-1 → 0.
- AXIS rules: tdata/tlast stay stable while tvalid & ~tready. doB is unchanged because enaB_q is low.
- Latency: wr_commit in cycle N with an empty pipeline gives enaB in N+1, enaB_q in N+2, tvalid in N+3.
- Throughput: 1 beat/cycle sustained while occupancy > 0 and tready = 1.
- Full stall: with tready low, v1 and v2 both fill and issue stops. At most 2 beats are in flight beyond occupancy.
- Reset mid-operation: in-flight beats are discarded and occupancy/pointers return to 0. Upstream must reset in the same cycle.

Test Plan (WIDTHA=16, WIDTHB=4, RATIO=4, SIZEB=16, ADDRWIDTHB=4, FRAME_LEN=6):
- Single commit of 0xDCBA, tready=1 -> addrB 0,1,2,3 on cycles N+1..N+4; tdata A,B,C,D on N+3..N+6; rd_credit in N+5; occupancy returns to 0.
- Commit 4 words back-to-back, tready=1 -> 16 contiguous beats; rd_ptr wraps 15→0; 4 credit pulses; tlast on beats 6, 12; beat_cnt=4 at end.
- tready low from the first valid, 2 commits -> tdata held at A; enaB issues exactly 2 reads then stops; occupancy=6. On release, 8 beats arrive in order with no loss or duplicate.
- Random tready (50%), 100 commits -> output equals the written narrow sequence; credits=100; tlast every 6th handshake.
- wr_commit with occupancy=13 -> overflow=1 (sticky), occupancy unchanged; simultaneous issue still decrements to 12.
- rst asserted while v1=v2=1 and occupancy=5 -> next cycle tvalid=0, enaB=0, occupancy=0, addrB=0, overflow=0.
